// File: rtl/exu_operand_stage.sv
// Decode-to-ALU operand pipeline register with a main register plus one skid entry.
// Optional macro EXU_FWD_EN enables writeback forwarding into rs1/rs2 at capture time.
module exu_operand_stage #(
    parameter int XLEN   = 64,
    parameter int MODE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [1:0]        in_asel,
    input  logic              in_bsel,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [4:0]        in_rd,
    input  logic              fwd_valid,
    input  logic [4:0]        fwd_rd,
    input  logic [XLEN-1:0]   fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_a,
    output logic [XLEN-1:0]   out_b,
    output logic [MODE_W-1:0] out_mode,
    output logic [4:0]        out_rd
);

    logic              main_valid;
    logic              skid_valid;
    logic [XLEN-1:0]   skid_a;
    logic [XLEN-1:0]   skid_b;
    logic [MODE_W-1:0] skid_mode;
    logic [4:0]        skid_rd;
    logic [XLEN-1:0]   rs1_eff;
    logic [XLEN-1:0]   rs2_eff;
    logic [XLEN-1:0]   sel_a;
    logic [XLEN-1:0]   sel_b;
    logic              in_fire;
    logic              main_load;

`ifdef EXU_FWD_EN
    // Forwarding applies only to the beat being captured; held beats keep their operands.
    always_comb begin
        rs1_eff = in_rs1_val;
        rs2_eff = in_rs2_val;
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs1)) begin
            rs1_eff = fwd_data;
        end
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs2)) begin
            rs2_eff = fwd_data;
        end
    end
`else
    logic fwd_unused;

    assign rs1_eff    = in_rs1_val;
    assign rs2_eff    = in_rs2_val;
    assign fwd_unused = ^{fwd_valid, fwd_rd, fwd_data, in_rs1, in_rs2};
`endif

    always_comb begin
        sel_a = '0;
        case (in_asel)
            2'd0:    sel_a = rs1_eff;
            2'd1:    sel_a = in_pc;
            default: sel_a = '0;
        endcase
        sel_b = in_bsel ? in_imm : rs2_eff;
    end

    assign in_ready  = ~rst & ~skid_valid;
    assign in_fire   = in_valid & in_ready;
    assign main_load = ~main_valid | out_ready;
    assign out_valid = main_valid;

    // The skid entry always drains into main before any newer beat, keeping order.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_mode   <= '0;
            out_rd     <= '0;
            skid_a     <= '0;
            skid_b     <= '0;
            skid_mode  <= '0;
            skid_rd    <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_load) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                out_a      <= skid_a;
                out_b      <= skid_b;
                out_mode   <= skid_mode;
                out_rd     <= skid_rd;
                skid_valid <= in_fire;
                if (in_fire) begin
                    skid_a    <= sel_a;
                    skid_b    <= sel_b;
                    skid_mode <= in_mode;
                    skid_rd   <= in_rd;
                end
            end else if (in_fire) begin
                main_valid <= 1'b1;
                out_a      <= sel_a;
                out_b      <= sel_b;
                out_mode   <= in_mode;
                out_rd     <= in_rd;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_a     <= sel_a;
            skid_b     <= sel_b;
            skid_mode  <= in_mode;
            skid_rd    <= in_rd;
        end
    end

endmodule

// File: tb/tb_exu_operand_stage.sv
// Directed bench for exu_operand_stage; a queue scoreboard tracks accepted beats in order.
module tb_exu_operand_stage;

    localparam int XLEN   = 64;
    localparam int MODE_W = 8;

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [MODE_W-1:0] mode;
        logic [4:0]        rd;
    } beat_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_rs1_val;
    logic [XLEN-1:0]   in_rs2_val;
    logic [XLEN-1:0]   in_imm;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [1:0]        in_asel;
    logic              in_bsel;
    logic [MODE_W-1:0] in_mode;
    logic [4:0]        in_rd;
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_a;
    logic [XLEN-1:0]   out_b;
    logic [MODE_W-1:0] out_mode;
    logic [4:0]        out_rd;

    int    checks;
    int    failures;
    beat_t sb[$];
    beat_t pending;

    exu_operand_stage #(.XLEN(XLEN), .MODE_W(MODE_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_asel(in_asel), .in_bsel(in_bsel), .in_mode(in_mode), .in_rd(in_rd),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_mode(out_mode), .out_rd(out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pops the oldest accepted beat and compares it with what the ALU side sees.
    task automatic checkOutput();
        beat_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("[TB] FAIL unexpected_output observed=a:%h expected=no_beat", out_a);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_out_a", out_a, e.a);
            chk("sb_out_b", out_b, e.b);
            chk("sb_out_mode", {56'd0, out_mode}, {56'd0, e.mode});
            chk("sb_out_rd", {59'd0, out_rd}, {59'd0, e.rd});
        end
    endtask

    task automatic tick();
        logic i_fire;
        logic o_fire;
        #1;
        i_fire = ((in_valid & in_ready) === 1'b1);
        o_fire = ((out_valid & out_ready) === 1'b1);
        if (rst) begin
            sb.delete();
        end else begin
            if (o_fire) checkOutput();
            if (flush) sb.delete();
            else if (i_fire) sb.push_back(pending);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] asel, input logic bsel,
                                 input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs1v,
                                 input logic [XLEN-1:0] rs2v, input logic [XLEN-1:0] imm,
                                 input logic [MODE_W-1:0] mode, input logic [4:0] rd,
                                 input logic ordy, input logic fl);
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        in_valid   = v;
        in_asel    = asel;
        in_bsel    = bsel;
        in_pc      = pc;
        in_rs1_val = rs1v;
        in_rs2_val = rs2v;
        in_imm     = imm;
        in_mode    = mode;
        in_rd      = rd;
        out_ready  = ordy;
        flush      = fl;
        r1 = rs1v;
        r2 = rs2v;
`ifdef EXU_FWD_EN
        if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rs1) r1 = fwd_data;
        if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rs2) r2 = fwd_data;
`endif
        pending.a    = (asel == 2'd0) ? r1 : ((asel == 2'd1) ? pc : '0);
        pending.b    = bsel ? imm : r2;
        pending.mode = mode;
        pending.rd   = rd;
        tick();
    endtask

    task automatic beat(input logic [XLEN-1:0] a, input logic ordy, input logic fl);
        applyStimulus(1'b1, 2'd0, 1'b1, 64'h0, a, 64'h0, a + 64'h1000, 8'd1, 5'd3, ordy, fl);
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 8'd0, 5'd0, ordy, 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_rs1 = 5'd1;
        in_rs2 = 5'd2;
        fwd_valid = 1'b0;
        fwd_rd = 5'd0;
        fwd_data = '0;

        // Reset held for two cycles
        idle(1'b1);
        idle(1'b1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_a", out_a, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        idle(1'b1);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Single beat, rs1 + immediate
        applyStimulus(1'b1, 2'd0, 1'b1, 64'h0, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0,
                      8'd0, 5'd5, 1'b1, 1'b0);
        chk("single_valid", {63'd0, out_valid}, 64'd1);
        chk("single_a", out_a, 64'h10);
        chk("single_b", out_b, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("single_rd", {59'd0, out_rd}, 64'd5);
        idle(1'b1);

        // Backpressure: main + skid fill, third beat waits
        beat(64'd1, 1'b0, 1'b0);
        beat(64'd2, 1'b0, 1'b0);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_hold_a1", out_a, 64'd1);
        beat(64'd3, 1'b0, 1'b0);
        chk("bp_hold_a2", out_a, 64'd1);
        beat(64'd3, 1'b1, 1'b0);
        chk("bp_release_a", out_a, 64'd2);
        beat(64'd3, 1'b1, 1'b0);
        chk("bp_third_a", out_a, 64'd3);

        // PC and zero selects
        applyStimulus(1'b1, 2'd1, 1'b0, 64'h8000_0000, 64'hDEAD, 64'd4, 64'h77,
                      8'd2, 5'd9, 1'b1, 1'b0);
        chk("pc_a", out_a, 64'h8000_0000);
        chk("pc_b", out_b, 64'd4);
        applyStimulus(1'b1, 2'd2, 1'b1, 64'h8000_0000, 64'hDEAD, 64'd4, 64'h77,
                      8'd10, 5'd31, 1'b1, 1'b0);
        chk("zero2_a", out_a, 64'd0);
        applyStimulus(1'b1, 2'd3, 1'b0, 64'h1234, 64'hBEEF, 64'h55AA, 64'h77,
                      8'd7, 5'd1, 1'b1, 1'b0);
        chk("zero3_a", out_a, 64'd0);
        chk("zero3_b", out_b, 64'h55AA);
        idle(1'b1);

        // Flush with main + skid full and a beat offered
        beat(64'h100, 1'b0, 1'b0);
        beat(64'h200, 1'b0, 1'b0);
        beat(64'h300, 1'b0, 1'b1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        // Flush drops a beat that fires in the same cycle
        beat(64'h400, 1'b0, 1'b0);
        beat(64'h500, 1'b0, 1'b1);
        chk("flush_drop_valid", {63'd0, out_valid}, 64'd0);
        // Output firing during flush is still consumed
        beat(64'h600, 1'b0, 1'b0);
        idle(1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 8'd0, 5'd0, 1'b1, 1'b1);
        chk("flush_fire_valid", {63'd0, out_valid}, 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Forwarding into rs1 and rs2
        in_rs1 = 5'd7;
        in_rs2 = 5'd8;
        fwd_valid = 1'b1;
        fwd_rd = 5'd7;
        fwd_data = 64'h55;
        applyStimulus(1'b1, 2'd0, 1'b1, 64'h0, 64'd1, 64'd2, 64'h9, 8'd0, 5'd4, 1'b1, 1'b0);
`ifdef EXU_FWD_EN
        chk("fwd_rs1_a", out_a, 64'h55);
`else
        chk("fwd_rs1_a", out_a, 64'd1);
`endif
        fwd_rd = 5'd0;
        in_rs1 = 5'd0;
        applyStimulus(1'b1, 2'd0, 1'b1, 64'h0, 64'd1, 64'd2, 64'h9, 8'd0, 5'd4, 1'b1, 1'b0);
        chk("fwd_rd0_a", out_a, 64'd1);
        fwd_rd = 5'd8;
        applyStimulus(1'b1, 2'd0, 1'b0, 64'h0, 64'd1, 64'd2, 64'h9, 8'd0, 5'd4, 1'b1, 1'b0);
        fwd_valid = 1'b0;
        in_rs1 = 5'd1;
        in_rs2 = 5'd2;
        idle(1'b1);

        // Back-to-back throughput with out_ready held high
        for (int i = 0; i < 4; i++) begin
            beat(64'h900 + 64'(i), 1'b1, 1'b0);
            chk("tput_valid", {63'd0, out_valid}, 64'd1);
            chk("tput_in_ready", {63'd0, in_ready}, 64'd1);
            chk("tput_a", out_a, 64'h900 + 64'(i));
        end
        idle(1'b1);

        // Reset while stalled with both entries full
        beat(64'h700, 1'b0, 1'b0);
        beat(64'h800, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1'b0);
        chk("rst_stall_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_stall_a", out_a, 64'd0);
        chk("rst_stall_b", out_b, 64'd0);
        chk("rst_stall_mode", {56'd0, out_mode}, 64'd0);
        chk("rst_stall_rd", {59'd0, out_rd}, 64'd0);
        rst = 1'b0;
        idle(1'b1);
        chk("rst_stall_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 8 && sb.size() != 0; i++) idle(1'b1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exu_operand_stage.md
Name: exu_operand_stage

Overview:
- Pipeline register between instruction decode and the execute-stage ALU.
- Selects ALU operands A and B from the register-file values, PC and immediate.
- Registers the operands together with the 8-bit ALU mode and destination register.
- Presents them to the ALU with a valid/ready handshake; a 2-entry skid buffer sustains one instruction per cycle under backpressure, and flush discards in-flight work on redirect.

Parameters:
- XLEN, 64, operand/data width.
- MODE_W, 8, ALU mode field width (0 add, 1 sub, 2 slt, 3 sltu, 4 and, 6 or, 7 xor, 8 sll, 9 srl, 10 sra).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discard all buffered and incoming entries.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_pc  input  XLEN  instruction PC.
- in_rs1_val  input  XLEN  register-file read data, port 1.
- in_rs2_val  input  XLEN  register-file read data, port 2.
- in_imm  input  XLEN  sign-extended immediate.
- in_rs1  input  5  rs1 index.
- in_rs2  input  5  rs2 index.
- in_asel  input  2  A select: 0 rs1_val, 1 pc, 2 zero, 3 zero.
- in_bsel  input  1  B select: 0 rs2_val, 1 imm.
- in_mode  input  MODE_W  ALU mode.
- in_rd  input  5  destination register.
- fwd_valid  input  1  writeback result valid (used only with EXU_FWD_EN).
- fwd_rd  input  5  writeback destination.
- fwd_data  input  XLEN  writeback data.
- out_valid  output  1  ALU operands valid.
- out_ready  input  1  ALU/downstream consumes this cycle.
- out_a  output  XLEN  ALU operand A.
- out_b  output  XLEN  ALU operand B.
- out_mode  output  MODE_W  ALU mode.
- out_rd  output  5  destination register.

Behaviour:
- Reset (rst=1 at edge): main_valid=0, skid_valid=0, and out_a/out_b/out_mode/out_rd are cleared to 0. While rst is high, in_ready=0.
- in_ready = ~rst & ~skid_valid. This is a function of registered state only; it has no combinational path from out_ready.
- Handshakes:
  - The input fires when in_valid & in_ready.
  - The output fires when out_valid & out_ready.
  - out_valid = main_valid.
- Operand select is done at capture time:
  - A is rs1_val, pc or 0 per in_asel.
  - B is rs2_val or imm per in_bsel.
  - Values are full XLEN with no truncation.
- Latency: an accepted beat appears on out_* on the next cycle when the main register is free.
- Main register loads when ~main_valid | out_ready:
  - If skid_valid, load from skid and clear skid, unless the input fires the same cycle, in which case the new beat refills skid.
  - Otherwise, if the input fires, load from the input.
  - Otherwise main_valid <= 0.
- Skid capture: the input fires while main_valid & ~out_ready, so the beat is stored in skid and skid_valid <= 1. in_ready then drops on the next cycle.
- Ordering: strictly in order. The skid entry always reaches the output before any later input beat.
- Stall hold: while out_valid & ~out_ready, out_a/out_b/out_mode/out_rd stay stable.
- Flush has priority over everything except rst:
  - main_valid and skid_valid are cleared next cycle.
  - An input beat that fires in the flush cycle is dropped.
  - An output firing in the flush cycle is still consumed by downstream; the stage takes no further action.
- Simultaneous output fire and input fire with skid empty: main takes the new beat, for a throughput of 1/cycle.
- Reset mid-stall: all entries are lost and outputs return to their reset values next cycle.

Optional Feature:
- Macro: EXU_FWD_EN.
- Defined: at capture, if fwd_valid & fwd_rd!=0 & fwd_rd==in_rs1, fwd_data replaces in_rs1_val (only matters when asel=0). Likewise fwd_data replaces in_rs2_val when fwd_rd==in_rs2 (only matters when bsel=0). The forward is sampled only at capture; beats already held in main/skid are not updated.
- Undefined: the fwd_* ports exist but are ignored, and operands come straight from the register file.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, out_a=0, in_ready=0. rst=0 -> in_ready=1.
- Single beat: asel=0, bsel=1, rs1_val=0x10, imm=0xFFFF_FFFF_FFFF_FFF0, mode=0, rd=5, out_ready=1 -> next cycle out_valid=1, out_a=0x10, out_b=0xFFFF_FFFF_FFFF_FFF0, out_mode=0, out_rd=5.
- Backpressure: stream beats with out_a=1,2,3 while out_ready=0 for 3 cycles -> skid holds 2, in_ready=0 from the next cycle, and out_a stays 1. Release -> outputs 1,2,3 in order, none lost or duplicated.
- PC/zero select: asel=1, pc=0x8000_0000, bsel=0, rs2_val=4 -> out_a=0x8000_0000, out_b=4. asel=2 -> out_a=0.
- Flush: main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed beats never appear.
- EXU_FWD_EN: in_rs1=7, rs1_val=1, fwd_valid=1, fwd_rd=7, fwd_data=0x55 -> out_a=0x55. With fwd_rd=0 -> out_a=1. Without the macro -> out_a=1.
